// File: rtl/lcd_cmd_seq_pkg.sv
// -----------------------------------------------------------------------------
// lcd_cmd_seq_pkg
//   Shared definitions for the HD44780-style LCD command sequencer:
//   FSM state encoding, RS pin meanings, default timer values and the
//   helpers that place a command byte onto the LCD data pins.
// -----------------------------------------------------------------------------
package lcd_cmd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_E_HI     = 3'd2,
        ST_HOLD     = 3'd3,
        ST_NEXT_NIB = 3'd4,
        ST_EXEC     = 3'd5
    } lcd_state_e;

    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;

    localparam logic [23:0] DEF_SETUP_CYC = 24'd2;
    localparam logic [23:0] DEF_PULSE_CYC = 24'd12;
    localparam logic [23:0] DEF_HOLD_CYC  = 24'd2;

    // Pin image for the first E pulse. A 4-bit bus only uses lcd_data[7:4],
    // so the high nibble goes out first and the unused pins stay low.
    function automatic logic [7:0] first_beat(input logic [7:0] data,
                                              input logic       nibble_mode);
        first_beat = nibble_mode ? {data[7:4], 4'h0} : data;
    endfunction

    // Pin image for the second E pulse of a 4-bit transfer (low nibble).
    function automatic logic [7:0] second_beat(input logic [7:0] data);
        second_beat = {data[3:0], 4'h0};
    endfunction

endpackage

// File: rtl/lcd_cmd_seq.sv
// -----------------------------------------------------------------------------
// lcd_cmd_seq
//   Command sequencer for an HD44780-style character LCD. Takes one command
//   per valid/ready handshake and drives RS/RW/E/data with setup, E-pulse and
//   hold timing, followed by the command's execution wait. All waits are
//   timed by an external dec_counter through timer_load/timer_value, and end
//   on its timer_expired pulse.
//
// Parameters
//   NIBBLE_MODE  0: 8-bit bus, one E pulse per command
//                1: 4-bit bus on lcd_data[7:4], high then low nibble
//   SETUP_CYC    timer value for RS/data setup before E rises
//   PULSE_CYC    timer value for E high time
//   HOLD_CYC     timer value for data hold after E falls
//
// Ports
//   clk            in   clock
//   rst            in   synchronous reset, active-low
//   cmd_valid      in   command available
//   cmd_ready      out  sequencer can accept (transfer on valid & ready)
//   cmd_rs         in   0 = instruction, 1 = data write
//   cmd_data       in   byte to write
//   cmd_single     in   4-bit mode only: send cmd_data[7:4] once
//   cmd_delay      in   execution wait after the final E pulse
//   busy           out  high from accept until the execution wait ends
//   timer_load     out  one-cycle load strobe to dec_counter
//   timer_value    out  load value, valid while timer_load = 1
//   timer_expired  in   expired pulse from dec_counter
//   lcd_rs         out  LCD RS pin
//   lcd_rw         out  LCD RW pin, tied low (write only)
//   lcd_e          out  LCD enable
//   lcd_data       out  LCD data pins
// -----------------------------------------------------------------------------
module lcd_cmd_seq
    import lcd_cmd_seq_pkg::*;
#(
    parameter bit          NIBBLE_MODE = 1'b0,
    parameter logic [23:0] SETUP_CYC   = DEF_SETUP_CYC,
    parameter logic [23:0] PULSE_CYC   = DEF_PULSE_CYC,
    parameter logic [23:0] HOLD_CYC    = DEF_HOLD_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rs,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_single,
    input  logic [23:0] cmd_delay,
    output logic        busy,
    output logic        timer_load,
    output logic [23:0] timer_value,
    input  logic        timer_expired,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data
);

    lcd_state_e  state_q;
    logic        cmd_ready_q;
    logic        busy_q;
    logic        timer_load_q;
    logic [23:0] timer_value_q;
    logic        lcd_rs_q;
    logic        lcd_e_q;
    logic [7:0]  lcd_data_q;

    logic [7:0]  data_q;       // latched command byte
    logic [23:0] delay_q;      // latched execution wait
    logic        second_q;     // low nibble still to be sent
    logic        load_dly_q;   // timer_load was high in the previous cycle

    // dec_counter cannot expire in the load cycle or the one after it, so any
    // pulse seen there is left over from an earlier wait and is ignored.
    logic        tmr_done;
    assign tmr_done = timer_expired && !timer_load_q && !load_dly_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            timer_load_q  <= 1'b0;
            timer_value_q <= 24'd0;
            lcd_rs_q      <= RS_INSTR;
            lcd_e_q       <= 1'b0;
            lcd_data_q    <= 8'h00;
            data_q        <= 8'h00;
            delay_q       <= 24'd0;
            second_q      <= 1'b0;
            load_dly_q    <= 1'b0;
        end else begin
            timer_load_q <= 1'b0;
            load_dly_q   <= timer_load_q;

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        data_q        <= cmd_data;
                        delay_q       <= cmd_delay;
                        second_q      <= NIBBLE_MODE && !cmd_single;
                        lcd_rs_q      <= cmd_rs;
                        lcd_data_q    <= first_beat(cmd_data, NIBBLE_MODE);
                        timer_load_q  <= 1'b1;
                        timer_value_q <= SETUP_CYC;
                        cmd_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (tmr_done) begin
                        lcd_e_q       <= 1'b1;
                        timer_load_q  <= 1'b1;
                        timer_value_q <= PULSE_CYC;
                        state_q       <= ST_E_HI;
                    end
                end

                ST_E_HI: begin
                    if (tmr_done) begin
                        lcd_e_q       <= 1'b0;
                        timer_load_q  <= 1'b1;
                        timer_value_q <= HOLD_CYC;
                        state_q       <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (tmr_done) begin
                        timer_load_q <= 1'b1;
                        if (second_q) begin
                            // The low nibble goes onto the pins together with the
                            // setup timer load, so its setup window is as long as
                            // the first nibble's.
                            second_q      <= 1'b0;
                            lcd_data_q    <= second_beat(data_q);
                            timer_value_q <= SETUP_CYC;
                            state_q       <= ST_NEXT_NIB;
                        end else begin
                            timer_value_q <= delay_q;
                            state_q       <= ST_EXEC;
                        end
                    end
                end

                // One-cycle pass-through: the setup timer is already running,
                // SETUP simply waits for it to expire.
                ST_NEXT_NIB: begin
                    state_q <= ST_SETUP;
                end

                ST_EXEC: begin
                    if (tmr_done) begin
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign timer_load  = timer_load_q;
    assign timer_value = timer_value_q;
    assign lcd_rs      = lcd_rs_q;
    assign lcd_rw      = 1'b0;
    assign lcd_e       = lcd_e_q;
    assign lcd_data    = lcd_data_q;

endmodule
